// File: rtl/lcd_stream_writer.sv
// Streams words from a first-word-fall-through FIFO onto an 8080-style LCD
// write bus, optionally holding frame-start words until the panel's tearing mark.
module lcd_stream_writer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int WR_LO      = 2,
    parameter int WR_HI      = 2,
    parameter int TE_TIMEOUT = 1048575
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_rs,
    input  logic                        in_sof,
    input  logic                        te_en,
    output logic [DATA_W-1:0]           lcd_data,
    output logic                        lcd_rs,
    output logic                        lcd_wr,
    input  logic                        lcd_fmark,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        te_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + 2;
    localparam int TW = $clog2(TE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TE_WAIT   = 2'd1,
        S_STROBE_LO = 2'd2,
        S_STROBE_HI = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_en_q, ready_en_d;
    logic              fm_sync1_q, fm_sync1_d;
    logic              fm_sync2_q, fm_sync2_d;
    logic              fm_prev_q, fm_prev_d;
    logic [3:0]        ph_cnt_q, ph_cnt_d;
    logic [TW-1:0]     te_cnt_q, te_cnt_d;
    logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
    logic              lcd_rs_q, lcd_rs_d;
    logic              lcd_wr_q, lcd_wr_d;
    logic              te_timeout_q, te_timeout_d;

    logic              push_s;
    logic              pop_s;
    logic              start_s;
    logic              empty_s;
    logic              gate_s;
    logic              fm_rise_s;
    logic [EW-1:0]     head_s;

    assign head_s    = mem_q[rd_ptr_q];
    assign empty_s   = (level_q == {LW{1'b0}});
    // A frame-start word at the head waits for the tearing mark only when enabled.
    assign gate_s    = head_s[DATA_W+1] & te_en;
    assign fm_rise_s = fm_sync2_q & ~fm_prev_q;
    assign in_ready  = ready_en_q & (level_q != LW'(FIFO_DEPTH));
    assign push_s    = in_valid & in_ready;

    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_wr     = lcd_wr_q;
    assign te_timeout = te_timeout_q;
    assign level      = level_q;
    assign busy       = (~empty_s) | (state_q != S_IDLE);

    // FIFO pointers, occupancy, ready enable and fmark synchroniser next-state.
    always_comb begin
        ready_en_d = 1'b1;
        fm_sync1_d = lcd_fmark;
        fm_sync2_d = fm_sync1_q;
        fm_prev_d  = fm_sync2_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + LW'(push_s) - LW'(pop_s);
    end

    // Write-strobe sequencer: dispatch, tearing wait, low and high phases.
    always_comb begin
        state_d      = state_q;
        ph_cnt_d     = ph_cnt_q;
        te_cnt_d     = te_cnt_q;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_wr_d     = lcd_wr_q;
        te_timeout_d = 1'b0;
        start_s      = 1'b0;
        pop_s        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (empty_s) begin
                    state_d = S_IDLE;
                end else if (gate_s) begin
                    state_d  = S_TE_WAIT;
                    te_cnt_d = {TW{1'b0}};
                end else begin
                    start_s = 1'b1;
                end
            end
            S_TE_WAIT: begin
                if (fm_rise_s) begin
                    start_s = 1'b1;
                end else if (te_cnt_q == TW'(TE_TIMEOUT - 1)) begin
                    start_s      = 1'b1;
                    te_timeout_d = 1'b1;
                end else begin
                    te_cnt_d = te_cnt_q + TW'(1);
                end
            end
            S_STROBE_LO: begin
                if (ph_cnt_q == 4'(WR_LO - 1)) begin
                    state_d  = S_STROBE_HI;
                    ph_cnt_d = 4'd0;
                    lcd_wr_d = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + 4'd1;
                end
            end
            S_STROBE_HI: begin
                if (ph_cnt_q != 4'(WR_HI - 1)) begin
                    ph_cnt_d = ph_cnt_q + 4'd1;
                end else if (empty_s) begin
                    state_d = S_IDLE;
                end else if (gate_s) begin
                    state_d  = S_TE_WAIT;
                    te_cnt_d = {TW{1'b0}};
                end else begin
                    start_s = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                lcd_wr_d = 1'b1;
            end
        endcase
        // Popping the head and dropping the strobe happen on the same edge.
        if (start_s) begin
            pop_s      = 1'b1;
            state_d    = S_STROBE_LO;
            ph_cnt_d   = 4'd0;
            lcd_wr_d   = 1'b0;
            lcd_data_d = head_s[DATA_W-1:0];
            lcd_rs_d   = head_s[DATA_W];
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage; contents are discarded on reset through the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_sof, in_rs, in_data};
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            level_q      <= {LW{1'b0}};
            ready_en_q   <= 1'b0;
            fm_sync1_q   <= 1'b0;
            fm_sync2_q   <= 1'b0;
            fm_prev_q    <= 1'b0;
            ph_cnt_q     <= 4'd0;
            te_cnt_q     <= {TW{1'b0}};
            lcd_data_q   <= {DATA_W{1'b0}};
            lcd_rs_q     <= 1'b0;
            lcd_wr_q     <= 1'b1;
            te_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            ready_en_q   <= ready_en_d;
            fm_sync1_q   <= fm_sync1_d;
            fm_sync2_q   <= fm_sync2_d;
            fm_prev_q    <= fm_prev_d;
            ph_cnt_q     <= ph_cnt_d;
            te_cnt_q     <= te_cnt_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_wr_q     <= lcd_wr_d;
            te_timeout_q <= te_timeout_d;
        end
    end

endmodule

// File: tb/tb_lcd_stream_writer.sv
// Self-checking bench for lcd_stream_writer: directed table, tearing/timeout/full/reset
// sequences, and randomized traffic against a word-ordering and occupancy model.
module tb_lcd_stream_writer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WLO   = 2;
    localparam int WHI   = 3;
    localparam int TTO   = 50;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_rs = 1'b0;
    logic          in_sof = 1'b0;
    logic          te_en = 1'b0;
    logic          lcd_fmark = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, lcd_rs, lcd_wr, busy, te_timeout;
    logic [DW-1:0] lcd_data;
    logic [LW-1:0] level;

    lcd_stream_writer #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WR_LO(WLO), .WR_HI(WHI), .TE_TIMEOUT(TTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rs(in_rs), .in_sof(in_sof), .te_en(te_en),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_fmark(lcd_fmark),
        .busy(busy), .level(level), .te_timeout(te_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rs;
        logic [DW-1:0] data;
    } word_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / monitor ----------------
    word_t exp_q[$];
    word_t got_q[$];
    int    gap_q[$];
    word_t w;
    int    push_cnt = 0, pop_cnt = 0, fall_total = 0, to_pulses = 0;
    int    low_len = 0, high_len = 0;
    logic  prev_wr = 1'b1, have_prev = 1'b0, mon_live = 1'b0;
    logic  prev_rs = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic  rdy_arm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_arm <= 1'b0;
        else        rdy_arm <= 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            push_cnt  = 0;
            pop_cnt   = 0;
            prev_wr   = 1'b1;
            low_len   = 0;
            high_len  = 0;
            have_prev = 1'b0;
            mon_live  = 1'b0;
        end else begin
            if (te_timeout) to_pulses++;
            if (prev_wr && !lcd_wr) begin
                pop_cnt++;
                fall_total++;
                gap_q.push_back(have_prev ? high_len : -1);
                if (have_prev) chk("min_high_gap", 32'(high_len >= WHI), 32'd1);
                got_q.push_back('{lcd_rs, lcd_data});
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_data", 32'(lcd_data), 32'(w.data));
                    chk("write_rs", 32'(lcd_rs), 32'(w.rs));
                end
                low_len = 1;
            end else if (!prev_wr && lcd_wr) begin
                chk("low_width", 32'(low_len), 32'(WLO));
                high_len  = 1;
                have_prev = 1'b1;
            end else if (!lcd_wr) begin
                low_len++;
            end else begin
                high_len++;
            end
            if (mon_live && !(prev_wr && !lcd_wr)) begin
                chk("data_hold", 32'(lcd_data), 32'(prev_data));
                chk("rs_hold", 32'(lcd_rs), 32'(prev_rs));
            end
            chk("level", 32'(level), 32'(push_cnt - pop_cnt));
            chk("in_ready", 32'(in_ready), 32'(rdy_arm && ((push_cnt - pop_cnt) != DEPTH)));
            if (in_valid && in_ready) begin
                push_cnt++;
                exp_q.push_back('{in_rs, in_data});
            end
            prev_wr   = lcd_wr;
            prev_data = lcd_data;
            prev_rs   = lcd_rs;
            mon_live  = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic rs, input logic [DW-1:0] d, input logic sof);
        logic acc;
        int   n;
        in_valid = 1'b1; in_rs = rs; in_data = d; in_sof = sof;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic          rs;
        logic [DW-1:0] data;
        logic          exp_rs;
        logic [DW-1:0] exp_data;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   n, f0, t0;
        logic saw_full, acc;

        tbl[0] = '{1'b0, 16'h002C, 1'b0, 16'h002C};
        tbl[1] = '{1'b1, 16'h0012, 1'b1, 16'h0012};
        tbl[2] = '{1'b1, 16'h0034, 1'b1, 16'h0034};
        tbl[3] = '{1'b1, 16'hC3A5, 1'b1, 16'hC3A5};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_wr", 32'(lcd_wr), 32'd1);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_data", 32'(lcd_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_te_timeout", 32'(te_timeout), 32'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        chk("ready_after_edge", 32'(in_ready), 32'd1);
        repeat (3) tick();

        // latency into empty FIFO: strobe falls on the second edge after in_valid
        push(1'b0, 16'h0077, 1'b0);
        chk("latency_edge1_wr", 32'(lcd_wr), 32'd1);
        tick();
        chk("latency_edge2_wr", 32'(lcd_wr), 32'd0);
        chk("latency_data", 32'(lcd_data), 32'h0077);
        wait_idle(100, "latency_idle");

        // table-driven burst: command then data words, back-to-back strobes
        got_q.delete();
        gap_q.delete();
        for (int i = 0; i < 4; i++) push(tbl[i].rs, tbl[i].data, 1'b0);
        wait_idle(200, "table_idle");
        chk("table_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                chk("table_data", 32'(got_q[i].data), 32'(tbl[i].exp_data));
                chk("table_rs", 32'(got_q[i].rs), 32'(tbl[i].exp_rs));
            end
            if (i > 0 && i < gap_q.size()) chk("table_period_hi", 32'(gap_q[i]), 32'(WHI));
        end

        // tearing sync: word waits for fmark, written 2..4 cycles after it rises
        te_en = 1'b1;
        t0 = to_pulses;
        push(1'b1, 16'h00AA, 1'b1);
        f0 = fall_total;
        repeat (20) tick();
        chk("te_wait_no_write", 32'(fall_total), 32'(f0));
        chk("te_wait_busy", 32'(busy), 32'd1);
        lcd_fmark = 1'b1;
        n = 0;
        while (lcd_wr && n < 10) begin
            tick();
            n++;
        end
        chk("fmark_latency_2to4", 32'(n >= 2 && n <= 4), 32'd1);
        chk("fmark_data", 32'(lcd_data), 32'h00AA);
        chk("fmark_rs", 32'(lcd_rs), 32'd1);
        wait_idle(100, "fmark_idle");
        chk("fmark_no_timeout", 32'(to_pulses), 32'(t0));
        lcd_fmark = 1'b0;
        repeat (4) tick();

        // tearing timeout: no fmark, pulse TE_TIMEOUT cycles after entering the wait
        push(1'b1, 16'h0055, 1'b1);
        n = 0;
        while (!te_timeout && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycle", 32'(n), 32'(TTO + 1));
        chk("timeout_wr_low", 32'(lcd_wr), 32'd0);
        chk("timeout_data", 32'(lcd_data), 32'h0055);
        tick();
        chk("timeout_single_pulse", 32'(te_timeout), 32'd0);
        wait_idle(100, "timeout_idle");
        chk("timeout_pulse_count", 32'(to_pulses - t0), 32'd1);
        te_en = 1'b0;

        // full FIFO: six words pushed as fast as accepted
        got_q.delete();
        gap_q.delete();
        saw_full = 1'b0;
        f0 = fall_total;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_rs = 1'b1; in_data = DW'(16'h1000 + i); in_sof = 1'b0;
            acc = 1'b0; n = 0;
            while (!acc && n < 50) begin
                if (!in_ready) begin
                    saw_full = 1'b1;
                    chk("full_level", 32'(level), 32'(DEPTH));
                end
                acc = in_ready;
                tick();
                n++;
            end
            chk("full_push_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        chk("full_seen", 32'(saw_full), 32'd1);
        n = 0;
        while ((fall_total - f0) < 6 && n < 200) begin
            tick();
            n++;
        end
        n = 0;
        while (!lcd_wr && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("busy_fall_after_whi", 32'(n), 32'(WHI));
        chk("full_level_zero", 32'(level), 32'd0);
        chk("full_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) chk("full_order", 32'(got_q[i].data), 32'(16'h1000 + i));
            if (i > 0 && i < gap_q.size()) chk("full_period_hi", 32'(gap_q[i]), 32'(WHI));
        end

        // reset during STROBE_LO of 0xBEEF with another word queued
        push(1'b1, 16'hBEEF, 1'b0);
        push(1'b1, 16'h1111, 1'b0);
        chk("pre_reset_wr_low", 32'(lcd_wr), 32'd0);
        chk("pre_reset_data", 32'(lcd_data), 32'hBEEF);
        chk("pre_reset_level", 32'(level), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(lcd_wr), 32'd1);
        chk("mid_rst_data", 32'(lcd_data), 32'd0);
        chk("mid_rst_rs", 32'(lcd_rs), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_ready_low", 32'(in_ready), 32'd0);
        f0 = fall_total;
        tick();
        chk("rel_ready_high", 32'(in_ready), 32'd1);
        repeat (20) tick();
        chk("rel_no_strobes", 32'(fall_total), 32'(f0));
        chk("rel_busy", 32'(busy), 32'd0);

        // randomized traffic against the ordering/occupancy model
        f0 = push_cnt;
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = DW'($urandom);
            in_rs    = 1'($urandom);
            in_sof   = ($urandom_range(0, 7) == 0);
            if (c % 100 == 0) te_en = 1'($urandom);
            if ($urandom_range(0, 15) == 0) lcd_fmark = ~lcd_fmark;
            tick();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        wait_idle(3000, "random_drain");
        chk("random_all_written", 32'(exp_q.size()), 32'd0);
        chk("random_push_pop", 32'(push_cnt), 32'(pop_cnt));
        chk("random_pushed_some", 32'(push_cnt > f0 + 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
